// File: rtl/grant_accumulator.sv
// Shared accumulator behind the round-robin arbiter: adds the granted requester's operand, then acks it.
// Four cycles per operand minimum: accept, add, ack, release (release waits for the grant to drop).
module grant_accumulator #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        grant,
    input  logic [N_REQ*DATA_W-1:0] data_in,
    input  logic                    clear,
    output logic [N_REQ-1:0]        ack,
    output logic [ACC_W-1:0]        sum,
    output logic [CNT_W-1:0]        count,
    output logic                    overflow,
    output logic                    grant_err,
    output logic                    busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ADD     = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] opnd_q, opnd_d;
    logic [ACC_W-1:0]  sum_q, sum_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              gerr_q, gerr_d;
    logic [N_REQ-1:0]  ack_q, ack_d;

    logic [IDX_W-1:0]  gidx;
    logic [DATA_W-1:0] gdata;
    logic              grant_one_hot;
    logic              grant_multi;
    logic [ACC_W:0]    add_full;

    always_comb begin
        gidx  = '0;
        gdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gidx  = IDX_W'(i);
                gdata = data_in[i*DATA_W +: DATA_W];
            end
        end
        grant_one_hot = (grant != '0) && ((grant & (grant - N_REQ'(1))) == '0);
        grant_multi   = (grant != '0) && !grant_one_hot;
        add_full      = {1'b0, sum_q} + {1'b0, ACC_W'(opnd_q)};
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opnd_d  = opnd_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        gerr_d  = gerr_q;
        ack_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_one_hot) begin
                    idx_d   = gidx;
                    opnd_d  = gdata;
                    state_d = S_ADD;
                end else if (grant_multi) begin
                    gerr_d = 1'b1;
                end
            end
            S_ADD: begin
                // clear coinciding with an add restarts the sum at this operand
                if (clear) begin
                    sum_d   = ACC_W'(opnd_q);
                    count_d = CNT_W'(1);
                    ovf_d   = 1'b0;
                end else begin
                    sum_d   = add_full[ACC_W-1:0];
                    count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                    ovf_d   = ovf_q | add_full[ACC_W];
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                ack_d   = N_REQ'(1) << idx_q;
                state_d = S_RELEASE;
            end
            default: begin
                if (!grant[idx_q]) state_d = S_IDLE;
            end
        endcase

        if (clear && state_q != S_ADD) begin
            sum_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            opnd_q  <= '0;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            gerr_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opnd_q  <= opnd_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            gerr_q  <= gerr_d;
            ack_q   <= ack_d;
        end
    end

    assign ack       = ack_q;
    assign sum       = sum_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign grant_err = gerr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_grant_accumulator.sv
// Directed bench for grant_accumulator: each task drives one scenario and checks hand-computed values.
module tb_grant_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  grant;
    logic [63:0] data_in;
    logic        clear;
    logic [3:0]  ack;
    logic [23:0] sum;
    logic [15:0] count;
    logic        overflow;
    logic        grant_err;
    logic        busy;

    int tests_run = 0;
    int fails = 0;

    grant_accumulator #(.N_REQ(4), .DATA_W(16), .ACC_W(24), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .grant(grant), .data_in(data_in), .clear(clear),
        .ack(ack), .sum(sum), .count(count), .overflow(overflow),
        .grant_err(grant_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [15:0] v);
        data_in[i*16 +: 16] = v;
    endtask

    // One full handshake; returns the ack vector seen (0 if none within the budget).
    task automatic do_op(input int i, input logic [15:0] v, output logic [3:0] a);
        a = 4'b0000;
        set_data(i, v);
        grant = 4'b0001 << i;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (ack != 4'b0000) begin
                a = ack;
                break;
            end
        end
        grant = 4'b0000;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; grant = 4'b0001; data_in = '0; clear = 1'b0;
        tick();
        tick();
        tests_run++; if (ack !== 4'b0000) begin fails++; $display("FAIL reset_ack got %b want 0000", ack); end
        tests_run++; if (sum !== 24'h0) begin fails++; $display("FAIL reset_sum got %h want 0", sum); end
        tests_run++; if (count !== 16'h0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        tests_run++; if ({overflow, grant_err, busy} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {overflow, grant_err, busy}); end
        rst_n = 1'b1;
        tick();
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_release_accept busy got %b want 1", busy); end
        tick();
        tick();
        tests_run++; if (ack !== 4'b0001) begin fails++; $display("FAIL reset_release_ack got %b want 0001", ack); end
        grant = 4'b0000;
        tick();
        tests_run++; if (count !== 16'd1) begin fails++; $display("FAIL reset_release_count got %0d want 1", count); end
        do_clear();
        tests_run++; if (count !== 16'd0) begin fails++; $display("FAIL clear_count got %0d want 0", count); end
    endtask

    task automatic test_single_add();
        set_data(2, 16'h1234);
        grant = 4'b0100;
        tick();                          // E
        set_data(2, 16'hBEEF);           // must not affect the add
        tests_run++; if (ack !== 4'b0000 || busy !== 1'b1) begin fails++; $display("FAIL single_E ack=%b busy=%b want 0000/1", ack, busy); end
        tick();                          // E+1
        tests_run++; if (sum !== 24'h001234) begin fails++; $display("FAIL single_sum got %h want 001234", sum); end
        tests_run++; if (count !== 16'd1) begin fails++; $display("FAIL single_count got %0d want 1", count); end
        tests_run++; if (ack !== 4'b0000) begin fails++; $display("FAIL single_ack_early got %b want 0000", ack); end
        tick();                          // E+2
        tests_run++; if (ack !== 4'b0100) begin fails++; $display("FAIL single_ack got %b want 0100", ack); end
        grant = 4'b0000;
        tick();                          // E+3
        tests_run++; if (ack !== 4'b0000 || busy !== 1'b0) begin fails++; $display("FAIL single_release ack=%b busy=%b want 0000/0", ack, busy); end
    endtask

    task automatic test_held_grant();
        int n_ack = 0;
        logic [3:0] last_ack = 4'b0000;
        logic [3:0] a;
        do_clear();
        set_data(1, 16'h0005);
        grant = 4'b0010;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (ack != 4'b0000) begin n_ack++; last_ack = ack; end
        end
        tests_run++; if (n_ack !== 1 || last_ack !== 4'b0010) begin fails++; $display("FAIL held_acks got %0d/%b want 1/0010", n_ack, last_ack); end
        tests_run++; if (sum !== 24'd5 || count !== 16'd1) begin fails++; $display("FAIL held_sum got %0d/%0d want 5/1", sum, count); end
        tests_run++; if (busy !== 1'b1) begin fails++; $display("FAIL held_busy got %b want 1", busy); end
        grant = 4'b0000;
        tick();
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL held_drop_busy got %b want 0", busy); end
        do_op(1, 16'h0005, a);
        tests_run++; if (a !== 4'b0010 || sum !== 24'd10 || count !== 16'd2) begin fails++; $display("FAIL held_reaccept ack=%b sum=%0d count=%0d want 0010/10/2", a, sum, count); end
    endtask

    task automatic test_round_robin();
        logic [3:0] a;
        do_clear();
        for (int i = 0; i < 4; i++) begin
            do_op(i, 16'(i + 1), a);
            tests_run++; if (a !== (4'b0001 << i)) begin fails++; $display("FAIL rr_ack%0d got %b want %b", i, a, 4'b0001 << i); end
        end
        tests_run++; if (sum !== 24'd10 || count !== 16'd4) begin fails++; $display("FAIL rr_total got %0d/%0d want 10/4", sum, count); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_busy got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        logic [3:0] a;
        int bad = 0;
        do_clear();
        for (int n = 0; n < 256; n++) begin
            do_op(n % 4, 16'hFFFF, a);
            if (a !== (4'b0001 << (n % 4))) bad++;
        end
        tests_run++; if (bad !== 0) begin fails++; $display("FAIL ovf_preload_acks got %0d bad want 0", bad); end
        tests_run++; if (sum !== 24'hFFFF00 || overflow !== 1'b0) begin fails++; $display("FAIL ovf_preload sum=%h ovf=%b want FFFF00/0", sum, overflow); end
        do_op(0, 16'h0100, a);
        tests_run++; if (sum !== 24'h000000 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_wrap sum=%h ovf=%b want 000000/1", sum, overflow); end
        do_op(3, 16'h0001, a);
        tests_run++; if (sum !== 24'h000001 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky sum=%h ovf=%b want 000001/1", sum, overflow); end
        tests_run++; if (count !== 16'd258) begin fails++; $display("FAIL ovf_count got %0d want 258", count); end
    endtask

    task automatic test_corners();
        int n_ack = 0;
        logic [23:0] sum_before;
        sum_before = sum;
        set_data(0, 16'h0011); set_data(2, 16'h0022);
        grant = 4'b0101;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ack != 4'b0000) n_ack++;
        end
        tests_run++; if (grant_err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL multi_err gerr=%b busy=%b want 1/0", grant_err, busy); end
        tests_run++; if (n_ack !== 0 || sum !== sum_before) begin fails++; $display("FAIL multi_ignored acks=%0d sum=%h want 0/%h", n_ack, sum, sum_before); end
        grant = 4'b0000;
        do_clear();
        tests_run++; if (grant_err !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL clear_keeps_gerr gerr=%b ovf=%b want 1/0", grant_err, overflow); end

        // clear coinciding with the add of 7 (sum is non-zero beforehand)
        do_op(1, 16'h0009, sum_before[3:0]);
        set_data(0, 16'h0007);
        grant = 4'b0001;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests_run++; if (sum !== 24'd7 || count !== 16'd1) begin fails++; $display("FAIL clear_in_add got %0d/%0d want 7/1", sum, count); end
        tick();
        tests_run++; if (ack !== 4'b0001) begin fails++; $display("FAIL clear_in_add_ack got %b want 0001", ack); end
        grant = 4'b0000;
        tick();

        // reset while ack is high
        set_data(3, 16'h0003);
        grant = 4'b1000;
        tick(); tick(); tick();
        tests_run++; if (ack !== 4'b1000) begin fails++; $display("FAIL rst_pre_ack got %b want 1000", ack); end
        rst_n = 1'b0;
        tick();
        tests_run++; if (ack !== 4'b0000 || sum !== 24'h0 || count !== 16'h0) begin fails++; $display("FAIL rst_mid ack=%b sum=%h count=%0d want 0000/0/0", ack, sum, count); end
        tests_run++; if ({overflow, grant_err, busy} !== 3'b000) begin fails++; $display("FAIL rst_mid_flags got %b want 000", {overflow, grant_err, busy}); end
        grant = 4'b0000;
        rst_n = 1'b1;
        n_ack = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (ack != 4'b0000) n_ack++;
        end
        tests_run++; if (n_ack !== 0) begin fails++; $display("FAIL rst_no_late_ack got %0d acks want 0", n_ack); end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_held_grant();
        test_round_robin();
        test_overflow();
        test_corners();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
